// File: rtl/time_set_ctrl.sv
// Time-setting sequencer: IDLE -> SET_H -> SET_M with shadow hour/minute edit,
// commit strobe, blink, inactivity timeout. Define TIME_SET_AUTO_REPEAT_EN for hold-to-repeat.
module time_set_ctrl #(
  parameter int TICK_W        = 16,
  parameter int HOLD_TICKS    = 500,
  parameter int REPEAT_TICKS  = 100,
  parameter int TIMEOUT_TICKS = 5000,
  parameter int BLINK_TICKS   = 250
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       tick,
  input  logic       set_p,
  input  logic       inc_p,
  input  logic       inc_lvl,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_mins,
  output logic [1:0] mode,
  output logic [4:0] hours,
  output logic [5:0] mins,
  output logic       load,
  output logic       blink,
  output logic       aborted
);

  typedef enum logic [1:0] {IDLE = 2'd0, SET_H = 2'd1, SET_M = 2'd2} state_t;

  localparam logic [TICK_W-1:0] TO_LAST = TICK_W'(TIMEOUT_TICKS - 1);
  localparam logic [TICK_W-1:0] TO_MAX  = TICK_W'(TIMEOUT_TICKS);
  localparam logic [TICK_W-1:0] BL_LAST = TICK_W'(BLINK_TICKS - 1);
  localparam logic [TICK_W-1:0] HD_LAST = TICK_W'(HOLD_TICKS - 1);
  localparam logic [TICK_W-1:0] RP_LAST = TICK_W'(REPEAT_TICKS - 1);

  state_t            state;
  logic [TICK_W-1:0] to_cnt;
  logic [TICK_W-1:0] blink_cnt;
  logic              editing;
  logic              rpt_fire;
  logic              lvl_clr;
  logic              inc_ev;
  logic              to_clr;
  logic              expire;

  assign mode    = state;
  assign editing = (state != IDLE);

`ifdef TIME_SET_AUTO_REPEAT_EN
  logic [TICK_W-1:0] hold_cnt;
  logic              rpt_phase;
  logic              hold_run;

  // A mode change (set_p) or release restarts the hold measurement.
  assign hold_run = editing && inc_lvl && !set_p;
  assign rpt_fire = hold_run && tick &&
                    (hold_cnt == (rpt_phase ? RP_LAST : HD_LAST));
  assign lvl_clr  = editing && inc_lvl;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      hold_cnt  <= '0;
      rpt_phase <= 1'b0;
    end else if (!hold_run || expire) begin
      hold_cnt  <= '0;
      rpt_phase <= 1'b0;
    end else if (tick) begin
      if (rpt_fire) begin
        hold_cnt  <= '0;
        rpt_phase <= 1'b1;
      end else begin
        hold_cnt  <= hold_cnt + 1'b1;
      end
    end
  end
`else
  logic              unused_inc_lvl;
  logic [TICK_W-1:0] unused_rpt;

  assign unused_inc_lvl = inc_lvl;
  assign unused_rpt     = HD_LAST ^ RP_LAST;
  assign rpt_fire       = 1'b0;
  assign lvl_clr        = 1'b0;
`endif

  // set_p outranks both increments and timeout expiry.
  assign inc_ev = editing && !set_p && (inc_p || rpt_fire);
  assign to_clr = set_p || inc_p || rpt_fire || lvl_clr;
  assign expire = editing && !to_clr && tick && (to_cnt == TO_LAST);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (!editing || to_clr) begin
      to_cnt <= '0;
    end else if (tick && to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hours     <= '0;
      mins      <= '0;
      load      <= 1'b0;
      blink     <= 1'b0;
      aborted   <= 1'b0;
      blink_cnt <= '0;
    end else begin
      load    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          blink     <= 1'b0;
          blink_cnt <= '0;
          if (set_p) begin
            state <= SET_H;
            hours <= cur_hours;
            mins  <= cur_mins;
            blink <= 1'b1;
          end
        end
        SET_H, SET_M: begin
          if (set_p) begin
            blink_cnt <= '0;
            if (state == SET_H) begin
              state <= SET_M;
              blink <= 1'b1;
            end else begin
              state <= IDLE;
              load  <= 1'b1;
              blink <= 1'b0;
            end
          end else if (expire) begin
            state     <= IDLE;
            aborted   <= 1'b1;
            blink     <= 1'b0;
            blink_cnt <= '0;
          end else if (inc_ev) begin
            // Keep the edited field lit right after each step.
            blink     <= 1'b1;
            blink_cnt <= '0;
            if (state == SET_H) hours <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
            else                mins  <= (mins == 6'd59)  ? 6'd0 : mins + 6'd1;
          end else if (tick) begin
            if (blink_cnt == BL_LAST) begin
              blink     <= ~blink;
              blink_cnt <= '0;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: reset, full edit, timeout, priority, blink, auto-repeat.
module tb_time_set_ctrl;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       tick   = 1'b0;
  logic       set_p  = 1'b0;
  logic       inc_p  = 1'b0;
  logic       inc_lvl = 1'b0;
  logic [4:0] cur_hours = '0;
  logic [5:0] cur_mins  = '0;
  logic [1:0] mode;
  logic [4:0] hours;
  logic [5:0] mins;
  logic       load;
  logic       blink;
  logic       aborted;

  int errors = 0;
  int checks = 0;
  int load_seen = 0;

  time_set_ctrl #(
    .TICK_W(16), .HOLD_TICKS(4), .REPEAT_TICKS(2), .TIMEOUT_TICKS(10), .BLINK_TICKS(3)
  ) dut (
    .sysclk(sysclk), .reset(reset), .tick(tick), .set_p(set_p), .inc_p(inc_p),
    .inc_lvl(inc_lvl), .cur_hours(cur_hours), .cur_mins(cur_mins), .mode(mode),
    .hours(hours), .mins(mins), .load(load), .blink(blink), .aborted(aborted)
  );

  always #5 sysclk = ~sysclk;

  always @(negedge sysclk) if (load === 1'b1) load_seen++;

  task automatic pulse_set();
    @(negedge sysclk); set_p = 1'b1;
    @(negedge sysclk); set_p = 1'b0;
  endtask

  task automatic pulse_inc();
    @(negedge sysclk); inc_p = 1'b1;
    @(negedge sysclk); inc_p = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge sysclk); tick = 1'b1;
    @(negedge sysclk); tick = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge sysclk); reset = 1'b0;
    @(negedge sysclk); reset = 1'b1;
  endtask

  task automatic test_reset();
    int l0;
    @(negedge sysclk);
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL rst_mode: got %0d exp 0", mode); end
    checks++; if (hours !== 5'd0) begin errors++; $display("FAIL rst_hours: got %0d exp 0", hours); end
    checks++; if (mins !== 6'd0) begin errors++; $display("FAIL rst_mins: got %0d exp 0", mins); end
    checks++; if ({load, blink, aborted} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b exp 000", {load, blink, aborted}); end
    reset = 1'b1;
    cur_hours = 5'd7; cur_mins = 6'd30;
    pulse_set();
    pulse_set();
    checks++; if (mode !== 2'd2 || hours !== 5'd7) begin errors++; $display("FAIL rst_pre: got mode %0d hours %0d exp 2/7", mode, hours); end
    l0 = load_seen;
    #2 reset = 1'b0;
    #1;
    checks++; if (mode !== 2'd0 || hours !== 5'd0 || mins !== 6'd0) begin errors++; $display("FAIL rst_async: got %0d %0d %0d exp 0 0 0", mode, hours, mins); end
    @(negedge sysclk); reset = 1'b1;
    repeat (3) @(negedge sysclk);
    checks++; if (mode !== 2'd0 || load_seen != l0) begin errors++; $display("FAIL rst_noload: got mode %0d loads %0d exp 0/0", mode, load_seen - l0); end
  endtask

  task automatic test_full_edit();
    int l0;
    l0 = load_seen;
    cur_hours = 5'd22; cur_mins = 6'd58;
    pulse_set();
    checks++; if (mode !== 2'd1 || hours !== 5'd22 || mins !== 6'd58) begin errors++; $display("FAIL edit_enter: got %0d %0d:%0d exp 1 22:58", mode, hours, mins); end
    checks++; if (blink !== 1'b1) begin errors++; $display("FAIL edit_blink: got %b exp 1", blink); end
    pulse_inc();
    pulse_inc();
    checks++; if (hours !== 5'd0) begin errors++; $display("FAIL edit_hwrap: got %0d exp 0", hours); end
    pulse_set();
    checks++; if (mode !== 2'd2) begin errors++; $display("FAIL edit_setm: got %0d exp 2", mode); end
    repeat (3) pulse_inc();
    checks++; if (mins !== 6'd1) begin errors++; $display("FAIL edit_mwrap: got %0d exp 1", mins); end
    @(negedge sysclk); set_p = 1'b1;
    @(negedge sysclk); set_p = 1'b0;
    checks++; if (load !== 1'b1 || mode !== 2'd0 || hours !== 5'd0 || mins !== 6'd1) begin errors++; $display("FAIL edit_commit: got load %b mode %0d %0d:%0d exp 1 0 0:1", load, mode, hours, mins); end
    @(negedge sysclk);
    checks++; if (load !== 1'b0 || load_seen - l0 != 1) begin errors++; $display("FAIL edit_load1: got load %b count %0d exp 0/1", load, load_seen - l0); end
    pulse_inc();
    checks++; if (hours !== 5'd0 || mins !== 6'd1 || mode !== 2'd0 || blink !== 1'b0) begin errors++; $display("FAIL idle_inc: got %0d:%0d mode %0d blink %b exp 0:1 0 0", hours, mins, mode, blink); end
  endtask

  task automatic test_timeout();
    int l0;
    l0 = load_seen;
    cur_hours = 5'd3; cur_mins = 6'd4;
    pulse_set();
    repeat (9) pulse_tick();
    checks++; if (mode !== 2'd1 || aborted !== 1'b0) begin errors++; $display("FAIL to_early: got mode %0d aborted %b exp 1/0", mode, aborted); end
    pulse_tick();
    checks++; if (aborted !== 1'b1 || mode !== 2'd0) begin errors++; $display("FAIL to_fire: got aborted %b mode %0d exp 1/0", aborted, mode); end
    @(negedge sysclk);
    checks++; if (aborted !== 1'b0 || load_seen != l0) begin errors++; $display("FAIL to_once: got aborted %b loads %0d exp 0/0", aborted, load_seen - l0); end
    // expiry coinciding with set_p must take the normal path
    pulse_set();
    repeat (9) pulse_tick();
    @(negedge sysclk); set_p = 1'b1; tick = 1'b1;
    @(negedge sysclk); set_p = 1'b0; tick = 1'b0;
    checks++; if (mode !== 2'd2 || aborted !== 1'b0) begin errors++; $display("FAIL to_vs_set: got mode %0d aborted %b exp 2/0", mode, aborted); end
    repeat (9) pulse_tick();
    checks++; if (mode !== 2'd2) begin errors++; $display("FAIL to_cleared: got mode %0d exp 2", mode); end
    pulse_set();
  endtask

  task automatic test_priority();
    apply_reset();
    cur_hours = 5'd5; cur_mins = 6'd10;
    pulse_set();
    @(negedge sysclk); set_p = 1'b1; inc_p = 1'b1;
    @(negedge sysclk); set_p = 1'b0; inc_p = 1'b0;
    checks++; if (mode !== 2'd2 || hours !== 5'd5 || mins !== 6'd10) begin errors++; $display("FAIL prio: got mode %0d %0d:%0d exp 2 5:10", mode, hours, mins); end
    pulse_set();
  endtask

  task automatic test_blink();
    bit [0:5] exp_b;
    bit [0:2] exp_r;
    apply_reset();
    cur_hours = 5'd1; cur_mins = 6'd2;
    pulse_set();
    checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_entry: got %b exp 1", blink); end
    exp_b = 6'b110001;
    for (int i = 0; i < 6; i++) begin
      pulse_tick();
      checks++; if (blink !== exp_b[i]) begin errors++; $display("FAIL blink_seq%0d: got %b exp %b", i, blink, exp_b[i]); end
    end
    pulse_tick();
    pulse_tick();
    pulse_inc();
    checks++; if (blink !== 1'b1 || hours !== 5'd2) begin errors++; $display("FAIL blink_inc: got blink %b hours %0d exp 1/2", blink, hours); end
    exp_r = 3'b110;
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      checks++; if (blink !== exp_r[i]) begin errors++; $display("FAIL blink_restart%0d: got %b exp %b", i, blink, exp_r[i]); end
    end
    apply_reset();
  endtask

  task automatic test_auto_repeat();
    int exp_m[8];
    int l0;
`ifdef TIME_SET_AUTO_REPEAT_EN
    exp_m = '{58, 58, 58, 59, 59, 0, 0, 1};
`else
    exp_m = '{58, 58, 58, 58, 58, 58, 58, 58};
`endif
    cur_hours = 5'd0; cur_mins = 6'd57;
    pulse_set();
    pulse_set();
    @(negedge sysclk); inc_p = 1'b1; inc_lvl = 1'b1;
    @(negedge sysclk); inc_p = 1'b0;
    checks++; if (mins !== 6'd58) begin errors++; $display("FAIL rpt_first: got %0d exp 58", mins); end
    for (int i = 0; i < 8; i++) begin
      pulse_tick();
      checks++; if (mins !== 6'(exp_m[i])) begin errors++; $display("FAIL rpt_tick%0d: got %0d exp %0d", i + 1, mins, exp_m[i]); end
    end
    inc_lvl = 1'b0;
    pulse_tick();
    checks++; if (mins !== 6'(exp_m[7]) || mode !== 2'd2) begin errors++; $display("FAIL rpt_release: got %0d mode %0d exp %0d/2", mins, mode, exp_m[7]); end
    l0 = load_seen;
    pulse_set();
    checks++; if (load !== 1'b1 || mins !== 6'(exp_m[7])) begin errors++; $display("FAIL rpt_commit: got load %b mins %0d exp 1/%0d", load, mins, exp_m[7]); end
    @(negedge sysclk);
    checks++; if (load_seen - l0 != 1) begin errors++; $display("FAIL rpt_load1: got %0d exp 1", load_seen - l0); end
  endtask

  initial begin
    test_reset();
    test_full_edit();
    test_timeout();
    test_priority();
    test_blink();
    test_auto_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
